// File: rtl/comparator_seq_chunked_if.sv
// comparator_seq_chunked_if: start/busy/done handshake and result bus of the chunked comparator
interface comparator_seq_chunked_if #(parameter int NBITS = 16, parameter int CHUNK = 4, parameter int CNTW = 8);
    localparam int CW = $clog2(NBITS / CHUNK) + 1;
    logic             start;
    logic [2:0]       mode;
    logic             is_signed;
    logic [NBITS-1:0] a;
    logic [NBITS-1:0] b;
    logic             busy;
    logic             done;
    logic             r;
    logic             err;
    logic [CW-1:0]    cycles;
    logic [CNTW-1:0]  match_count;
    modport master (output start, mode, is_signed, a, b, input busy, done, r, err, cycles, match_count);
    modport slave  (input start, mode, is_signed, a, b, output busy, done, r, err, cycles, match_count);
endinterface

// File: rtl/comparator_seq_chunked.sv
// comparator_seq_chunked: MSB-chunk-first sequential magnitude/equality compare with early exit
module comparator_seq_chunked #(
    parameter int NBITS = 16,
    parameter int CHUNK = 4,
    parameter int CNTW  = 8
) (
    input  logic clk,
    input  logic rst,
    comparator_seq_chunked_if.slave bus
);
    localparam int NCH = NBITS / CHUNK;
    localparam int CW  = $clog2(NCH) + 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, nxt;
    logic [NBITS-1:0] sa, sb;
    logic [2:0] m;
    logic sg;
    logic [CW-1:0] idx;
    logic [CHUNK-1:0] ca, cb, flip;
    logic c_lt, c_gt, c_eq, fin, res;
    logic r, err;
    logic [CW-1:0] cycles;
    logic [CNTW-1:0] match_count;
    always_ff @(posedge clk)
        if (rst) state <= IDLE;
        else state <= nxt;
    // Operands shift left each RUN cycle so the chunk under test is always the top one
    always_comb begin
        flip = '0;
        flip[CHUNK-1] = sg && idx == '0;
        ca = sa[NBITS-1 -: CHUNK] ^ flip;
        cb = sb[NBITS-1 -: CHUNK] ^ flip;
        c_lt = ca < cb;
        c_gt = ca > cb;
        c_eq = !c_lt && !c_gt;
        fin = !c_eq || idx == CW'(NCH - 1);
        res = m == 3'd0 ? c_eq : m == 3'd1 ? !c_eq : m == 3'd2 ? c_lt :
              m == 3'd3 ? !c_gt : m == 3'd4 ? c_gt : m == 3'd5 ? !c_lt : 1'b0;
        nxt = state == IDLE ? (bus.start ? RUN : IDLE) :
              state == RUN  ? (fin ? DONE : RUN) : IDLE;
    end
    always_ff @(posedge clk)
        if (rst) begin
            sa <= '0;
            sb <= '0;
            m <= '0;
            sg <= 1'b0;
            idx <= '0;
            r <= 1'b0;
            err <= 1'b0;
            cycles <= '0;
            match_count <= '0;
        end else if (state == IDLE && bus.start) begin
            sa <= bus.a;
            sb <= bus.b;
            m <= bus.mode;
            sg <= bus.is_signed;
            idx <= '0;
        end else if (state == RUN) begin
            sa <= sa << CHUNK;
            sb <= sb << CHUNK;
            idx <= idx + 1'b1;
            if (fin) begin
                r <= res;
                err <= m > 3'd5;
                cycles <= idx + 1'b1;
                if (res && match_count != '1) match_count <= match_count + 1'b1;
            end
        end
    assign bus.busy = state == RUN;
    assign bus.done = state == DONE;
    assign bus.r = r;
    assign bus.err = err;
    assign bus.cycles = cycles;
    assign bus.match_count = match_count;
endmodule

// File: tb/tb_comparator_seq_chunked.sv
// tb_comparator_seq_chunked: directed vectors with a queue scoreboard checked on every done pulse
module tb_comparator_seq_chunked;
    logic clk = 0;
    logic rst = 1;
    int checks = 0;
    int passes = 0;
    int mc_exp = 0;
    typedef struct packed {logic r; logic err; logic [2:0] k; logic [7:0] mc;} exp_t;
    exp_t q[$];
    comparator_seq_chunked_if #(.NBITS(16), .CHUNK(4), .CNTW(8)) ifc ();
    comparator_seq_chunked #(.NBITS(16), .CHUNK(4), .CNTW(8)) dut (.clk(clk), .rst(rst), .bus(ifc.slave));
    always #5 clk = ~clk;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act === expv) passes++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    endtask
    always @(negedge clk)
        if (ifc.done) begin
            if (q.size() == 0) chk("unexpected_done", 1, 0);
            else begin
                exp_t e;
                e = q.pop_front();
                chk("r", ifc.r, e.r);
                chk("err", ifc.err, e.err);
                chk("cycles", ifc.cycles, e.k);
                chk("match_count", ifc.match_count, e.mc);
            end
        end
    task automatic zero_state(input string nm);
        chk({nm, "_busy"}, ifc.busy, 0);
        chk({nm, "_done"}, ifc.done, 0);
        chk({nm, "_r"}, ifc.r, 0);
        chk({nm, "_err"}, ifc.err, 0);
        chk({nm, "_cycles"}, ifc.cycles, 0);
        chk({nm, "_match_count"}, ifc.match_count, 0);
    endtask
    task automatic op(input logic [15:0] ta, input logic [15:0] tb_, input logic [2:0] m, input logic s,
                      input logic er, input logic ee, input int k, input logic disturb);
        int n;
        @(negedge clk);
        ifc.a = ta; ifc.b = tb_; ifc.mode = m; ifc.is_signed = s; ifc.start = 1;
        if (er && mc_exp != 255) mc_exp++;
        q.push_back('{er, ee, 3'(k), 8'(mc_exp)});
        @(posedge clk); #1;
        ifc.start = 0;
        n = 0;
        while (!ifc.done && n < 20) begin
            if (disturb) begin
                ifc.start = ifc.busy;
                ifc.a = ~ifc.a;
                ifc.mode = 3'd1;
            end
            @(posedge clk); #1;
            n++;
        end
        ifc.start = 0;
        chk("latency", n, k);
        @(posedge clk); #1;
    endtask
    initial begin
        ifc.start = 0; ifc.mode = 0; ifc.is_signed = 0; ifc.a = 0; ifc.b = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        zero_state("reset");
        op(16'h1234, 16'h1234, 3'd0, 0, 1, 0, 4, 0);
        op(16'h1000, 16'h2000, 3'd4, 0, 0, 0, 1, 0);
        op(16'h1000, 16'h2000, 3'd2, 0, 1, 0, 1, 0);
        op(16'hFFFF, 16'h0001, 3'd2, 1, 1, 0, 1, 0);
        op(16'hFFFF, 16'h0001, 3'd2, 0, 0, 0, 1, 0);
        op(16'h8000, 16'h7FFF, 3'd5, 1, 0, 0, 1, 0);
        op(16'h1234, 16'h1235, 3'd3, 0, 1, 0, 4, 0);
        op(16'h1234, 16'h1235, 3'd1, 0, 1, 0, 4, 0);
        op(16'h00A5, 16'h00A5, 3'd6, 0, 0, 1, 4, 0);
        op(16'h1234, 16'h1234, 3'd0, 0, 1, 0, 4, 1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        ifc.a = 16'h5555; ifc.b = 16'h5555; ifc.mode = 0; ifc.is_signed = 0; ifc.start = 1;
        @(posedge clk); #1 ifc.start = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1;
        chk("mid_run_busy", ifc.busy, 1);
        @(posedge clk); #1 rst = 0;
        mc_exp = 0;
        zero_state("mid_run_reset");
        repeat (6) @(posedge clk);
        #1 chk("idle_after_reset", ifc.busy, 0);
        op(16'hBEEF, 16'hBEEF, 3'd0, 1, 1, 0, 4, 0);
        for (int i = 0; i < 300; i++) op(16'(i * 7), 16'(i * 7), 3'd0, i[0], 1, 0, 4, 0);
        op(16'h0F00, 16'h0E00, 3'd7, 0, 0, 1, 2, 0);
        repeat (4) @(posedge clk);
        #1 chk("queue_empty", q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/comparator_seq_chunked.md
Name: comparator_seq_chunked

Overview:
Multi-cycle magnitude/equality comparator. It is the sequential, mode-selectable successor to the team's combinational N-bit equality comparator. Operands are compared CHUNK bits per cycle, MSB chunk first, and the comparison terminates early on the first differing chunk. It sits behind a start/busy/done handshake, keeps a saturating count of true results, and is intended for datapaths where a full-width compare in one cycle misses timing.

Parameters:
NBITS, 16, operand width; must be a multiple of CHUNK.
CHUNK, 4, bits compared per cycle; NCH = NBITS/CHUNK chunks.
CNTW, 8, width of match_count.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
start  input  1  request a comparison; sampled only in IDLE.
mode  input  3  0=EQ 1=NE 2=LT 3=LE 4=GT 5=GE; 6,7 reserved.
is_signed  input  1  1 = two's-complement operands.
a  input  NBITS  operand A.
b  input  NBITS  operand B.
busy  output  1  high in RUN.
done  output  1  one-cycle pulse when result valid.
r  output  1  comparison result (A mode B).
err  output  1  latched with r; 1 if mode was reserved.
cycles  output  clog2(NCH)+1  chunks examined for the last result.
match_count  output  CNTW  completed ops with r=1, saturating.

Behaviour:
- Reset: state=IDLE; busy, done, r, err, cycles and match_count all 0. Reset wins over every other event, including mid-RUN; the operation in flight is discarded and no done is produced.
- States: IDLE, RUN, DONE.
- IDLE: if start=1, latch a, b, mode and is_signed; set chunk index i=0 (MSB chunk); go to RUN. Input changes after this edge have no effect on the operation.
- RUN: busy=1. Each cycle compares chunk i (bits NBITS-1-i*CHUNK down to NBITS-(i+1)*CHUNK) as unsigned values.
- Signed mode, chunk 0 only: invert the MSB of both chunk values before the compare (offset-binary).
- If the chunks differ, record lt/gt and go to DONE.
- If they are equal and i=NCH-1, record eq and go to DONE. Otherwise i=i+1.
- DONE: a single cycle. done=1; r, err and cycles update at the DONE-entry edge. Then go to IDLE.
- Latency: with start sampled at edge T0 and k chunks examined (1..NCH), done is high in the cycle after edge T0+k. Worst case is NCH+1 cycles from start to done, including the DONE cycle.
- Result: r = f(mode, lt, eq, gt). A reserved mode gives r=0, err=1, and the compare still runs normally.
- cycles = k.
- match_count increments at the DONE-entry edge when r=1. It holds at 2^CNTW-1 and does not wrap.
- r, err and cycles hold their values until the next DONE entry or reset.
- start in RUN or DONE is ignored and not queued. start may be asserted in the same cycle done is high; it is taken at the following IDLE.
- Back-to-back throughput: one operation per k+2 cycles.

Test Plan:
1. Reset, then a=b=16'h1234, mode=EQ, unsigned, start for 1 cycle -> busy for 4 cycles, done after edge T0+4, r=1, cycles=4, match_count=1.
2. a=16'h1000, b=16'h2000, mode=GT -> done after edge T0+1, r=0, cycles=1. Repeat with mode=LT -> r=1, match_count increments.
3. a=16'hFFFF, b=16'h0001, mode=LT: is_signed=1 -> r=1; is_signed=0 -> r=0; both cycles=1. Also a=16'h8000 vs b=16'h7FFF, GE, signed -> r=0.
4. Start pulses while busy=1, operands changed mid-RUN -> no extra done; result reflects the latched operands only.
5. rst=1 during RUN chunk 2 -> next cycle all outputs 0, state IDLE, no done. A new start then works normally.
6. 300 back-to-back EQ ops with a=b -> match_count stops at 255. mode=7 -> r=0, err=1, match_count unchanged.
